shift_mult_sequencer: RTL

Sequencing controller for the right-shift operand register in the serial multiplier datapath. It loads the multiplier operand into an external right-shift register, then shifts it once per cycle. It inspects the register's LSB each cycle, accumulates a left-shifting copy of the multiplicand into a 2×Word_Length product, and reports completion with a one-cycle done pulse. Requesters use a start/ready handshake; the block also supports abort.

---
 rtl/shift_mult_sequencer.sv | 105 ++++++++++
 1 files changed

// File: rtl/shift_mult_sequencer.sv
// Serial shift-add multiplier controller driving an external right-shift operand register.
// Latency Word_Length+3 cycles from start accept to ready; start is ignored (not queued) while ready=0.
module shift_mult_sequencer #(
    parameter int Word_Length = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [Word_Length-1:0]     multiplicand,
    input  logic [Word_Length-1:0]     multiplier,
    input  logic                       sr_lsb,
    output logic                       sr_load,
    output logic                       sr_shift,
    output logic [Word_Length-1:0]     sr_data,
    output logic                       ready,
    output logic                       busy,
    output logic                       done,
    output logic [2*Word_Length-1:0]   product
);

    localparam int CW = $clog2(Word_Length + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t                    state;
    state_t                    state_nxt;
    logic [CW-1:0]             count;
    logic [2*Word_Length-1:0]  mcand_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_load   = 1'b0;
        sr_shift  = 1'b0;
        ready     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                sr_load = 1'b1;
                busy    = 1'b1;
                state_nxt = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                sr_shift = 1'b1;
                busy     = 1'b1;
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (count == CW'(Word_Length - 1)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The multiplicand copy doubles each RUN cycle so it stays aligned with the bit now at sr_lsb.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_data   <= '0;
            mcand_reg <= '0;
            product   <= '0;
            count     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr_data   <= multiplier;
                        mcand_reg <= {{Word_Length{1'b0}}, multiplicand};
                        product   <= '0;
                        count     <= '0;
                    end
                end
                S_RUN: begin
                    if (sr_lsb) product <= product + mcand_reg;
                    mcand_reg <= mcand_reg << 1;
                    count     <= count + CW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
